// File: rtl/mac_seq_ctrl.sv
// Sequencer for a 4-lane MAC: streams LEN chunks into the MAC, feeds the running sum
// back as psum, and returns the final sum through an output valid/ready handshake.
module mac_seq_ctrl #(
    parameter int unsigned bw      = 4,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned cnt_bw  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [cnt_bw-1:0]   len,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*bw-1:0]     in_x,
    input  logic [4*bw-1:0]     in_w,
    output logic [4*bw-1:0]     mac_x,
    output logic [4*bw-1:0]     mac_w,
    output logic [psum_bw-1:0]  mac_psum,
    input  logic [psum_bw-1:0]  mac_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [psum_bw-1:0]  out_data,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [psum_bw-1:0]  acc;
    logic [cnt_bw-1:0]   cnt;
    logic [cnt_bw-1:0]   cnt_inc;
    logic [cnt_bw-1:0]   len_q;
    logic                stage_v;
    logic                accept;

    assign accept    = (state == RUN) && in_valid;
    assign cnt_inc   = cnt + cnt_bw'(1);
    assign in_ready  = (state == RUN);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = acc;
    assign mac_psum  = acc;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (accept && (cnt_inc == len_q)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: state_nxt = DONE;
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            len_q   <= '0;
            stage_v <= 1'b0;
            mac_x   <= '0;
            mac_w   <= '0;
        end else begin
            state   <= state_nxt;
            // stage_v marks the cycle in which mac_out reflects the chunk accepted last cycle
            stage_v <= accept;
            if (accept) begin
                mac_x <= in_x;
                mac_w <= in_w;
                cnt   <= cnt_inc;
            end
            if ((state == IDLE) && start) begin
                acc   <= '0;
                cnt   <= '0;
                len_q <= len;
            end else if (stage_v) begin
                acc <= mac_out;
            end
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a behavioural 4-lane MAC closing the psum loop.
module tb_mac_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] in_w;
    logic [15:0] mac_x;
    logic [15:0] mac_w;
    logic [15:0] mac_psum;
    logic [15:0] mac_out;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mac_seq_ctrl #(
        .bw      (4),
        .psum_bw (16),
        .cnt_bw  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .mac_x     (mac_x),
        .mac_w     (mac_w),
        .mac_psum  (mac_psum),
        .mac_out   (mac_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // MAC: sum of unsigned x times signed w over 4 lanes, plus psum, wrapped to 16 bits
    function automatic logic [15:0] mac_model(input logic [15:0] x, input logic [15:0] w,
                                              input logic [15:0] psum);
        int s;
        logic signed [3:0] wl;
        s = int'($signed(psum));
        for (int i = 0; i < 4; i++) begin
            wl = w[4*i +: 4];
            s += int'(x[4*i +: 4]) * int'(wl);
        end
        return s[15:0];
    endfunction

    assign mac_out = mac_model(mac_x, mac_w, mac_psum);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [7:0] n);
        start = 1'b1;
        len   = n;
        tick();
        start = 1'b0;
    endtask

    task automatic chunk(input logic [15:0] x, input logic [15:0] w);
        in_valid = 1'b1;
        in_x     = x;
        in_w     = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        if (!out_valid) check({tag, "_timeout"}, 32'(out_valid), 32'd1);
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        in_x = '0; in_w = '0; out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);

        // 1: single chunk, dot = 1+2+3+4
        start_job(8'd1);
        check("t1_in_ready", 32'(in_ready), 32'd1);
        c = cyc;
        chunk(16'h4321, 16'h1111);
        check("t1_drain_valid", 32'(out_valid), 32'd0);
        check("t1_drain_ready", 32'(in_ready),  32'd0);
        check("t1_drain_busy",  32'(busy),      32'd1);
        wait_out("t1");
        check("t1_latency", 32'(cyc - c), 32'd2);
        check("t1_data", 32'(out_data), 32'd10);
        take_result();
        check("t1_idle_busy", 32'(busy),     32'd0);
        check("t1_retained",  32'(out_data), 32'd10);

        // 2: three chunks at full rate, each -480
        c = cyc;
        start_job(8'd3);
        for (int i = 0; i < 3; i++) chunk(16'hFFFF, 16'h8888);
        wait_out("t2");
        check("t2_latency", 32'(cyc - c), 32'd5);
        check("t2_data", 32'(out_data), 32'h0000FA60);
        take_result();

        // 3: bubbles between two chunks of 6
        start_job(8'd2);
        chunk(16'h0002, 16'h0003);
        for (int g = 0; g < 3; g++) begin
            check("t3_gap_ready", 32'(in_ready),  32'd1);
            check("t3_gap_valid", 32'(out_valid), 32'd0);
            check("t3_gap_x",     32'(mac_x),     32'h0002);
            if (g > 0) check("t3_gap_acc", 32'(mac_psum), 32'd6);
            tick();
        end
        chunk(16'h0002, 16'h0003);
        check("t3_drain_ready", 32'(in_ready), 32'd0);
        wait_out("t3");
        check("t3_data", 32'(out_data), 32'd12);
        take_result();

        // 4: empty job completes immediately with 0 and holds under backpressure
        start_job(8'd0);
        check("t4_valid", 32'(out_valid), 32'd1);
        check("t4_data",  32'(out_data),  32'd0);
        check("t4_busy",  32'(busy),      32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_data",  32'(out_data),  32'd0);
        end
        take_result();
        check("t4_released", 32'(out_valid), 32'd0);

        // 5: reset in the middle of a job, then a fresh job
        start_job(8'd4);
        chunk(16'h1111, 16'h1111);
        chunk(16'h1111, 16'h1111);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_busy",      32'(busy),      32'd0);
        check("t5_acc",       32'(out_data),  32'd0);
        check("t5_in_ready",  32'(in_ready),  32'd0);
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_mac_x",     32'(mac_x),     32'd0);
        start_job(8'd1);
        chunk(16'h4321, 16'h1111);
        wait_out("t5");
        check("t5_data", 32'(out_data), 32'd10);
        take_result();

        // 6: start pulses during RUN and in the DONE handshake are ignored
        start_job(8'd2);
        start = 1'b1;
        len   = 8'd1;
        chunk(16'h0005, 16'h0007);
        start = 1'b0;
        check("t6_still_run", 32'(in_ready), 32'd1);
        chunk(16'h0005, 16'h0007);
        wait_out("t6");
        check("t6_data", 32'(out_data), 32'd70);
        start = 1'b1;
        len   = 8'd3;
        take_result();
        start = 1'b0;
        check("t6_hs_busy",  32'(busy),      32'd0);
        check("t6_hs_valid", 32'(out_valid), 32'd0);
        check("t6_hs_data",  32'(out_data),  32'd70);
        tick();
        check("t6_idle_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
